// File: rtl/bit_tally_accum.sv
// Accumulates per-byte ones/zeros counts over a fixed-length frame and hands the
// frame totals, a balance flag and an integrity flag downstream over valid/ready.
module bit_tally_accum #(
  parameter int FRAME_LEN = 64,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             byte_valid,
  input  logic [3:0]       num0,
  input  logic [3:0]       num1,
  input  logic             frame_abort,
  output logic             byte_ready,
  output logic             tally_valid,
  input  logic             tally_ready,
  output logic [CNT_W-1:0] ones_total,
  output logic [CNT_W-1:0] zeros_total,
  output logic             balanced,
  output logic             count_err
);

  // Wide enough to hold FRAME_LEN itself, which is the count while a frame is held.
  localparam int BC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  ones_q, ones_d;
  logic [CNT_W-1:0]  zeros_q, zeros_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic              count_err_q, count_err_d;
  logic              balanced_q, balanced_d;
  logic              tally_valid_q, tally_valid_d;
  logic              byte_ready_q, byte_ready_d;

  logic              accept;
  logic              clear;
  logic              last_byte;
  logic [4:0]        byte_sum;

  // Abort outranks everything; a held frame is released only by the handshake.
  assign clear     = frame_abort || ((state_q == S_HOLD) && tally_ready);
  assign accept    = !frame_abort && byte_ready_q && byte_valid;
  assign last_byte = (byte_cnt_q == BC_W'(FRAME_LEN - 1));
  assign byte_sum  = {1'b0, num0} + {1'b0, num1};

  // NOTE: every variable gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    ones_d        = ones_q;
    zeros_d       = zeros_q;
    byte_cnt_d    = byte_cnt_q;
    count_err_d   = count_err_q;
    balanced_d    = balanced_q;
    tally_valid_d = tally_valid_q;

    if (clear) begin
      state_d       = S_IDLE;
      ones_d        = '0;
      zeros_d       = '0;
      byte_cnt_d    = '0;
      count_err_d   = 1'b0;
      balanced_d    = 1'b0;
      tally_valid_d = 1'b0;
    end else if (accept) begin
      ones_d     = ones_q + CNT_W'(num1);
      zeros_d    = zeros_q + CNT_W'(num0);
      byte_cnt_d = byte_cnt_q + BC_W'(1);
      if (byte_sum != 5'd8) begin
        count_err_d = 1'b1;
      end
      if (last_byte) begin
        state_d       = S_HOLD;
        tally_valid_d = 1'b1;
        balanced_d    = (ones_d == zeros_d);
      end else begin
        state_d = S_ACCUM;
      end
    end

    // Registered so upstream sees no combinational path from our inputs.
    byte_ready_d = (state_d != S_HOLD);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= S_IDLE;
      ones_q        <= '0;
      zeros_q       <= '0;
      byte_cnt_q    <= '0;
      count_err_q   <= 1'b0;
      balanced_q    <= 1'b0;
      tally_valid_q <= 1'b0;
      byte_ready_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      ones_q        <= ones_d;
      zeros_q       <= zeros_d;
      byte_cnt_q    <= byte_cnt_d;
      count_err_q   <= count_err_d;
      balanced_q    <= balanced_d;
      tally_valid_q <= tally_valid_d;
      byte_ready_q  <= byte_ready_d;
    end
  end

  assign byte_ready  = byte_ready_q;
  assign tally_valid = tally_valid_q;
  assign ones_total  = ones_q;
  assign zeros_total = zeros_q;
  assign balanced    = balanced_q;
  assign count_err   = count_err_q;

endmodule

// File: tb/tb_bit_tally_accum.sv
// Randomised and directed bench for bit_tally_accum: a 4-byte-frame instance
// against a queue-based frame model, and a 64-byte-frame instance for width.
module tb_bit_tally_accum;

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: short frames
  logic       a_byte_valid, a_frame_abort, a_tally_ready;
  logic [3:0] a_num0, a_num1;
  logic       a_byte_ready, a_tally_valid, a_balanced, a_count_err;
  logic [5:0] a_ones, a_zeros;
  logic [15:0] a_obs;

  bit_tally_accum #(.FRAME_LEN(4), .CNT_W(6)) dut_a (
    .clk(clk), .n_rst(n_rst),
    .byte_valid(a_byte_valid), .num0(a_num0), .num1(a_num1),
    .frame_abort(a_frame_abort), .byte_ready(a_byte_ready),
    .tally_valid(a_tally_valid), .tally_ready(a_tally_ready),
    .ones_total(a_ones), .zeros_total(a_zeros),
    .balanced(a_balanced), .count_err(a_count_err)
  );

  assign a_obs = {a_byte_ready, a_tally_valid, a_ones, a_zeros, a_balanced, a_count_err};

  // Instance B: full-size frames
  logic       b_byte_valid, b_frame_abort, b_tally_ready;
  logic [3:0] b_num0, b_num1;
  logic       b_byte_ready, b_tally_valid, b_balanced, b_count_err;
  logic [9:0] b_ones, b_zeros;

  bit_tally_accum #(.FRAME_LEN(64), .CNT_W(10)) dut_b (
    .clk(clk), .n_rst(n_rst),
    .byte_valid(b_byte_valid), .num0(b_num0), .num1(b_num1),
    .frame_abort(b_frame_abort), .byte_ready(b_byte_ready),
    .tally_valid(b_tally_valid), .tally_ready(b_tally_ready),
    .ones_total(b_ones), .zeros_total(b_zeros),
    .balanced(b_balanced), .count_err(b_count_err)
  );

  // Model for A: the bytes accepted into the current frame.
  typedef struct { int n1; int n0; } byte_t;
  byte_t frame_q[$];

  function automatic logic [15:0] a_expect();
    int  ones = 0, zeros = 0;
    bit  err = 0;
    bit  full;
    full = (frame_q.size() == 4);
    foreach (frame_q[i]) begin
      ones  += frame_q[i].n1;
      zeros += frame_q[i].n0;
      if (frame_q[i].n1 + frame_q[i].n0 != 8) err = 1;
    end
    return {!full, full, 6'(ones), 6'(zeros), full && (ones == zeros), err};
  endfunction

  // One clock on instance A; the model follows the frame rules.
  task automatic cycle_a(input bit v, input int n1, input int n0,
                         input bit abort, input bit tready);
    bit full;
    a_byte_valid  = v;
    a_num1        = 4'(n1);
    a_num0        = 4'(n0);
    a_frame_abort = abort;
    a_tally_ready = tready;
    full = (frame_q.size() == 4);
    @(posedge clk);
    if (abort) frame_q.delete();
    else if (full) begin
      if (tready) frame_q.delete();
    end else if (v) frame_q.push_back('{n1, n0});
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    a_byte_valid = 1'b1; a_num1 = 4'd8; a_num0 = 4'd0;
    a_frame_abort = 1'b0; a_tally_ready = 1'b0;
    b_byte_valid = 1'b1; b_num1 = 4'd8; b_num0 = 4'd0;
    b_frame_abort = 1'b0; b_tally_ready = 1'b0;
    frame_q.delete();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (a_obs !== 16'h8000) begin
      errors++;
      $display("FAIL reset_a got=%h exp=%h", a_obs, 16'h8000);
    end
    checks++;
    if ({b_byte_ready, b_tally_valid, b_ones, b_zeros, b_balanced, b_count_err} !== {1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_b got rdy=%b tv=%b ones=%0d zeros=%0d bal=%b err=%b",
               b_byte_ready, b_tally_valid, b_ones, b_zeros, b_balanced, b_count_err);
    end
    a_byte_valid = 1'b0;
    b_byte_valid = 1'b0;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_frame();
    int n1s[4] = '{8, 0, 4, 3};
    int n0s[4] = '{0, 8, 4, 5};
    for (int i = 0; i < 4; i++) begin
      cycle_a(1'b1, n1s[i], n0s[i], 1'b0, 1'b1);
      checks++;
      if (a_obs !== a_expect()) begin
        errors++;
        $display("FAIL basic_byte%0d got=%h exp=%h", i, a_obs, a_expect());
      end
    end
    checks++;
    if ({a_tally_valid, a_ones, a_zeros, a_balanced, a_count_err} !== {1'b1, 6'd15, 6'd17, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_totals got tv=%b ones=%0d zeros=%0d bal=%b err=%b exp 1/15/17/0/0",
               a_tally_valid, a_ones, a_zeros, a_balanced, a_count_err);
    end
    cycle_a(1'b0, 0, 0, 1'b0, 1'b1);
    checks++;
    if (a_obs !== 16'h8000) begin
      errors++;
      $display("FAIL basic_release got=%h exp=%h", a_obs, 16'h8000);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) cycle_a(1'b1, 4, 4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle_a(1'b1, 8, 0, 1'b0, 1'b0);
      checks++;
      if ({a_byte_ready, a_tally_valid, a_ones, a_zeros, a_balanced} !== {1'b0, 1'b1, 6'd16, 6'd16, 1'b1}) begin
        errors++;
        $display("FAIL hold_stable cyc%0d got=%h", i, a_obs);
      end
    end
    cycle_a(1'b1, 8, 0, 1'b0, 1'b1);   // handshake; held byte not counted
    cycle_a(1'b1, 8, 0, 1'b0, 1'b0);   // first byte of next frame
    checks++;
    if ({a_tally_valid, a_ones, a_zeros} !== {1'b0, 6'd8, 6'd0} || a_obs !== a_expect()) begin
      errors++;
      $display("FAIL hold_next_frame got=%h exp=%h", a_obs, a_expect());
    end
    for (int i = 0; i < 3; i++) cycle_a(1'b1, 0, 8, 1'b0, 1'b0);
    cycle_a(1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_count_err();
    cycle_a(1'b1, 5, 5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle_a(1'b1, 4, 4, 1'b0, 1'b0);
    checks++;
    if ({a_tally_valid, a_ones, a_zeros, a_balanced, a_count_err} !== {1'b1, 6'd17, 6'd17, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL err_set got=%h exp=%h", a_obs, a_expect());
    end
    cycle_a(1'b0, 0, 0, 1'b0, 1'b1);
    checks++;
    if (a_count_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got=%b exp=0", a_count_err);
    end
    for (int i = 0; i < 4; i++) cycle_a(1'b1, 2, 6, 1'b0, 1'b0);
    checks++;
    if ({a_tally_valid, a_count_err, a_ones} !== {1'b1, 1'b0, 6'd8}) begin
      errors++;
      $display("FAIL err_clean_frame got=%h exp=%h", a_obs, a_expect());
    end
    cycle_a(1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    cycle_a(1'b1, 7, 1, 1'b0, 1'b0);
    cycle_a(1'b1, 3, 3, 1'b0, 1'b0);
    cycle_a(1'b1, 8, 0, 1'b1, 1'b0);
    checks++;
    if (a_obs !== 16'h8000) begin
      errors++;
      $display("FAIL abort_clear got=%h exp=%h", a_obs, 16'h8000);
    end
    for (int i = 0; i < 4; i++) cycle_a(1'b1, 6, 2, 1'b0, 1'b0);
    checks++;
    if ({a_tally_valid, a_ones, a_zeros, a_count_err} !== {1'b1, 6'd24, 6'd8, 1'b0}) begin
      errors++;
      $display("FAIL abort_fresh_frame got=%h exp=%h", a_obs, a_expect());
    end
    cycle_a(1'b1, 1, 1, 1'b1, 1'b0);   // abort also drops a held frame
    checks++;
    if (a_obs !== 16'h8000) begin
      errors++;
      $display("FAIL abort_hold got=%h exp=%h", a_obs, 16'h8000);
    end
  endtask

  task automatic test_reset_mid_frame();
    cycle_a(1'b1, 8, 0, 1'b0, 1'b0);
    cycle_a(1'b1, 8, 0, 1'b0, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    frame_q.delete();
    checks++;
    if (a_obs !== 16'h8000) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", a_obs, 16'h8000);
    end
    a_byte_valid = 1'b0;
    @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic test_random();
    int n1, n0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        n1 = $urandom_range(0, 15);
        n0 = $urandom_range(0, 15);
      end else begin
        n1 = $urandom_range(0, 8);
        n0 = 8 - n1;
      end
      cycle_a($urandom_range(0, 2) != 0, n1, n0, $urandom_range(0, 24) == 0,
              $urandom_range(0, 1) == 1);
      checks++;
      if (a_obs !== a_expect()) begin
        errors++;
        $display("FAIL random cyc%0d got=%h exp=%h", c, a_obs, a_expect());
      end
    end
    cycle_a(1'b0, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_long_frame();
    int  accepted = 0;
    bit  early = 0;
    b_num1 = 4'd8; b_num0 = 4'd0; b_tally_ready = 1'b0; b_frame_abort = 1'b0;
    for (int c = 0; c < 2000 && accepted < 64; c++) begin
      b_byte_valid = ($urandom_range(0, 2) != 0);
      if (b_byte_valid && b_byte_ready) accepted++;
      @(posedge clk);
      #1;
      if (accepted < 64 && b_tally_valid) early = 1;
    end
    b_byte_valid = 1'b0;
    checks++;
    if (accepted != 64 || early) begin
      errors++;
      $display("FAIL long_progress accepted=%0d early_valid=%b exp 64/0", accepted, early);
    end
    checks++;
    if ({b_byte_ready, b_tally_valid, b_ones, b_zeros, b_balanced, b_count_err} !== {1'b0, 1'b1, 10'd512, 10'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL long_totals got rdy=%b tv=%b ones=%0d zeros=%0d bal=%b err=%b exp 0/1/512/0/0/0",
               b_byte_ready, b_tally_valid, b_ones, b_zeros, b_balanced, b_count_err);
    end
    b_tally_ready = 1'b1;
    @(posedge clk);
    #1;
    b_tally_ready = 1'b0;
    checks++;
    if ({b_byte_ready, b_tally_valid, b_ones} !== {1'b1, 1'b0, 10'd0}) begin
      errors++;
      $display("FAIL long_release got rdy=%b tv=%b ones=%0d", b_byte_ready, b_tally_valid, b_ones);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_count_err();
    test_abort();
    test_reset_mid_frame();
    test_random();
    test_long_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
